// File: rtl/tower_pkg.sv
// Shared definitions for the tower and its upstream damage queue.
package tower_pkg;

    localparam int unsigned TOWER_DMG_W = 8;

    typedef enum logic [2:0] {
        QI     = 3'b100,
        QRun   = 3'b010,
        QFlush = 3'b001
    } q_state_t;

endpackage

// File: rtl/damage_fifo.sv
// Synchronous FIFO with combinational head output and single-cycle clear.
module damage_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/tower_damage_queue.sv
// Round-robin collector of unit damage requests; releases one buffered hit per game tick.
module tower_damage_queue
    import tower_pkg::*;
#(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DMG_W   = TOWER_DMG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gameTick,
    input  logic                     startLevel,
    input  logic                     towerDead,
    input  logic [N_UNITS-1:0]       attackReq,
    input  logic [N_UNITS*DMG_W-1:0] attackDmg,
    output logic [N_UNITS-1:0]       attackAck,
    output logic [DMG_W-1:0]         damageOut,
    output logic                     attackSCEN,
    output logic [$clog2(DEPTH):0]   queueCount
);
    localparam int unsigned PW = $clog2(N_UNITS);

    q_state_t      state, state_nxt;
    logic [PW-1:0] rrPtr, rr_nxt;
    logic [PW-1:0] gnt, idx;
    logic          found;
    logic          push, pop, clear, full, empty;
    logic [DMG_W-1:0] head;

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            idx = PW'((32'(rrPtr) + k) % N_UNITS);
            if (!found && attackReq[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rrPtr;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        attackAck = '0;
        unique case (state)
            QI: if (startLevel) state_nxt = QRun;
            QRun: begin
                if (towerDead) begin
                    state_nxt = QFlush;
                end else begin
                    pop = gameTick && !empty;
                    if (found && (!full || pop)) begin
                        push           = 1'b1;
                        attackAck[gnt] = 1'b1;
                        rr_nxt = (gnt == PW'(N_UNITS-1)) ? '0 : gnt + PW'(1);
                    end
                end
            end
            QFlush: begin
                clear     = 1'b1;
                rr_nxt    = '0;
                state_nxt = QI;
            end
            default: state_nxt = QI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= QI;
            rrPtr      <= '0;
            attackSCEN <= 1'b0;
            damageOut  <= '0;
        end else begin
            state      <= state_nxt;
            rrPtr      <= rr_nxt;
            attackSCEN <= pop;
            if (pop) damageOut <= head;
        end
    end

    damage_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DMG_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (attackDmg[32'(gnt)*DMG_W +: DMG_W]),
        .dout  (head),
        .count (queueCount),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_tower_damage_queue.sv
// Directed, table-driven bench for tower_damage_queue (N_UNITS=4, DEPTH=8, DMG_W=8).
module tb_tower_damage_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        gameTick, startLevel, towerDead;
    logic [3:0]  attackReq;
    logic [31:0] attackDmg;
    logic [3:0]  attackAck;
    logic [7:0]  damageOut;
    logic        attackSCEN;
    logic [3:0]  queueCount;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        s, d, t;
        logic [3:0]  req;
        logic [31:0] dmg;
        logic [3:0]  ack;
        logic        scen;
        logic [7:0]  dout;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    tower_damage_queue #(.N_UNITS(4), .DEPTH(8), .DMG_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .gameTick   (gameTick),
        .startLevel (startLevel),
        .towerDead  (towerDead),
        .attackReq  (attackReq),
        .attackDmg  (attackDmg),
        .attackAck  (attackAck),
        .damageOut  (damageOut),
        .attackSCEN (attackSCEN),
        .queueCount (queueCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, d, t, input logic [3:0] req, input logic [31:0] dmg,
                                input logic [3:0] ack, input logic scen, input logic [7:0] dout,
                                input logic [3:0] cnt);
        vec_t v;
        v.s = s; v.d = d; v.t = t; v.req = req; v.dmg = dmg;
        v.ack = ack; v.scen = scen; v.dout = dout; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [31:0] lanes(input logic [7:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        // start,dead,tick, req, dmg | ack, scen, dout, count (after the edge)
        vecs.push_back(mk(1,0,0,4'b0000, 0,                 4'b0000,0, 0,0)); // 0
        vecs.push_back(mk(0,0,0,4'b0100, lanes(0,10,0,0),   4'b0100,0, 0,1));
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1,10,0));
        vecs.push_back(mk(0,0,0,4'b0000, 0,                 4'b0000,0,10,0));
        vecs.push_back(mk(0,1,0,4'b0000, 0,                 4'b0000,0,10,0)); // back to QI: rrPtr=0
        vecs.push_back(mk(0,0,0,4'b0000, 0,                 4'b0000,0,10,0));
        vecs.push_back(mk(1,0,0,4'b0000, 0,                 4'b0000,0,10,0));
        vecs.push_back(mk(0,0,0,4'b1111, lanes(4,3,2,1),    4'b0001,0,10,1)); // 7
        vecs.push_back(mk(0,0,0,4'b1110, lanes(4,3,2,1),    4'b0010,0,10,2));
        vecs.push_back(mk(0,0,0,4'b1100, lanes(4,3,2,1),    4'b0100,0,10,3));
        vecs.push_back(mk(0,0,0,4'b1000, lanes(4,3,2,1),    4'b1000,0,10,4));
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1, 1,3)); // 11
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1, 2,2));
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1, 3,1));
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1, 4,0));
        vecs.push_back(mk(0,0,0,4'b0000, 0,                 4'b0000,0, 4,0)); // 15
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0,0,0,4'b0001, 32'(20+i), 4'b0001,0,4,4'(i+1))); // 16..23
        vecs.push_back(mk(0,0,0,4'b0001, 99,                4'b0000,0, 4,8)); // 24 full, blocked
        vecs.push_back(mk(0,0,1,4'b0001, 99,                4'b0001,1,20,8)); // 25 pop+push
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1,21,7));
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1,22,6));
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1,23,5));
        vecs.push_back(mk(0,1,1,4'b0001, 99,                4'b0000,0,23,5)); // 29 dead: no push/pop
        vecs.push_back(mk(0,0,1,4'b0001, 99,                4'b0000,0,23,0)); // flush
        vecs.push_back(mk(0,0,1,4'b0001, 99,                4'b0000,0,23,0)); // idle
        vecs.push_back(mk(1,0,0,4'b0001, 5,                 4'b0000,0,23,0)); // 32
        vecs.push_back(mk(0,0,0,4'b0001, 5,                 4'b0001,0,23,1));
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1, 5,0));
        vecs.push_back(mk(0,0,0,4'b0001, 0,                 4'b0001,0, 5,1)); // 35 zero damage
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1, 0,0));
        vecs.push_back(mk(0,0,1,4'b0010, lanes(0,0,7,0),    4'b0010,0, 0,1)); // 37 push into empty + tick
        vecs.push_back(mk(0,0,1,4'b0000, 0,                 4'b0000,1, 7,0));
        vecs.push_back(mk(0,0,0,4'b0101, lanes(0,12,0,11),  4'b0100,0, 7,1)); // 39 rrPtr=2
        vecs.push_back(mk(0,0,0,4'b0001, lanes(0,0,0,11),   4'b0001,0, 7,2));
        vecs.push_back(mk(0,0,0,4'b0010, lanes(0,0,13,0),   4'b0010,0, 7,3));

        reset = 1'b0; gameTick = 0; startLevel = 0; towerDead = 0; attackReq = '0; attackDmg = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",  0, 32'(attackAck),  0);
        chk("rst_dout", 0, 32'(damageOut),  0);
        chk("rst_scen", 0, 32'(attackSCEN), 0);
        chk("rst_cnt",  0, 32'(queueCount), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            startLevel = vecs[i].s; towerDead = vecs[i].d; gameTick = vecs[i].t;
            attackReq  = vecs[i].req; attackDmg = vecs[i].dmg;
            #1;
            chk("ack", i, 32'(attackAck), 32'(vecs[i].ack));
            @(posedge clk);
            #1;
            chk("scen", i, 32'(attackSCEN), 32'(vecs[i].scen));
            chk("dout", i, 32'(damageOut),  32'(vecs[i].dout));
            chk("cnt",  i, 32'(queueCount), 32'(vecs[i].cnt));
        end

        // Reset mid-operation with 3 entries queued and a tick pending.
        @(negedge clk);
        startLevel = 0; towerDead = 0; attackReq = '0; attackDmg = '0; gameTick = 1;
        #2 reset = 1'b0;
        #1;
        chk("midrst_ack",  100, 32'(attackAck),  0);
        chk("midrst_dout", 100, 32'(damageOut),  0);
        chk("midrst_scen", 100, 32'(attackSCEN), 0);
        chk("midrst_cnt",  100, 32'(queueCount), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_scen", 101 + i, 32'(attackSCEN), 0);
            chk("postrst_cnt",  101 + i, 32'(queueCount), 0);
            chk("postrst_dout", 101 + i, 32'(damageOut),  0);
        end
        // Level restart after reset: queue is genuinely empty, ticks still produce nothing.
        @(negedge clk);
        startLevel = 1;
        @(negedge clk);
        startLevel = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("restart_scen", 110 + i, 32'(attackSCEN), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tower_damage_queue.md
# tower_damage_queue

Upstream feeder for the tower block. Collects damage requests from up to `N_UNITS` attacking units through a round-robin arbiter and buffers them in a small FIFO. On each game tick it releases one buffered hit as a single-cycle `attackSCEN` pulse with `damageOut` valid, so the tower never sees two hits in one cycle. Sits between the unit instances and the tower's `damageIn`/`attackSCEN` inputs, and tracks the tower's level lifecycle through `startLevel` and `towerDead`.

## Interface
Parameters:
- `N_UNITS`, 4: number of unit request lanes (≥2).
- `DEPTH`, 8: FIFO entries (power of two).
- `DMG_W`, 8: damage width; must match the tower's `damageIn`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `gameTick`  in  1  single-`clk` enable marking one game step.
- `startLevel`  in  1  level start; same signal the tower receives.
- `towerDead`  in  1  the tower's `dead` output.
- `attackReq`  in  `N_UNITS`  per-unit request; held high until acked.
- `attackDmg`  in  `N_UNITS*DMG_W`  per-unit damage; lane i is bits `[i*DMG_W +: DMG_W]`.
- `attackAck`  out  `N_UNITS`  one-hot accept, combinational, same cycle as the push.
- `damageOut`  out  `DMG_W`  registered damage to the tower.
- `attackSCEN`  out  1  registered one-cycle strobe; `damageOut` is valid in the same cycle.
- `queueCount`  out  `$clog2(DEPTH)+1`  current FIFO occupancy.

## Operation
- State machine (one-hot, 3 bits):
  - QI: idle. No acks, no pops. Go to QRun when `startLevel` is high.
  - QRun: arbitrate, push and pop.
    - If `towerDead` is high, go to QFlush. That cycle performs no push and no pop.
  - QFlush: clear the FIFO (pointers and count to 0) and the round-robin pointer in one cycle, then go to QI.
- Arbitration (QRun only):
  - Search order starts at `rrPtr` and wraps modulo `N_UNITS`. The first requester found is granted.
  - The grant is accepted only if `count < DEPTH`, or if `count == DEPTH` and a pop happens in the same cycle.
  - On accept: raise `attackAck[g]`, push `attackDmg` lane g, and set `rrPtr <= (g+1) mod N_UNITS`.
  - On no accept: no ack, and `rrPtr` is unchanged.
  - At most one push per cycle.
- Pop (QRun only): on `gameTick` with `count > 0`, dequeue the head into `damageOut` and set `attackSCEN` high for exactly the next cycle.
- Zero-damage entries are queued and issued like any other entry.
- Simultaneous push and pop: `count` is unchanged. A push into an empty FIFO cannot be popped in the same cycle; the earliest pop is on the next tick.
- Reset values, all outputs: `attackAck=0`, `damageOut=0`, `attackSCEN=0`, `queueCount=0`. Internal: state QI, `rrPtr=0`.
- Reset asserted mid-operation discards all queued damage immediately; no strobe is emitted afterward.
- `damageOut` holds its last popped value between strobes. It is cleared only by reset.

## Timing
- Request to ack: 0 cycles when accepted; the unit drops `attackReq` on the next edge.
- `gameTick` in cycle t with a non-empty FIFO produces `attackSCEN` and the new `damageOut` in cycle t+1.
- Minimum push-to-strobe latency: a push at cycle t, with a tick at t+1, gives the strobe at t+2.
- Throughput: one pop per tick, one push per cycle.
- `towerDead` seen in QRun at cycle t: QFlush at t+1, QI at t+2, `queueCount=0` from t+2.
- An `attackSCEN` already registered for cycle t+1 still fires.

## Structure
- Shared package `tower_pkg` holds:
  - state encodings `QI=3'b100`, `QRun=3'b010`, `QFlush=3'b001`;
  - default `DMG_W=8`, shared with the tower.
- One sub-module: `damage_fifo`, a synchronous FIFO.
  - Parameters `DEPTH` and `WIDTH`.
  - Ports: `push`, `pop`, `clear`, `din`, `dout`, `count`, `full`, `empty`.
  - Wrap-around uses pointers of `$clog2(DEPTH)` bits.
- The arbiter and state machine live in the top module.

## Test plan
- Reset then `startLevel`; unit 2 requests damage 10, then one `gameTick` → `attackAck=4'b0100` in the same cycle; one cycle later `attackSCEN=1`, `damageOut=10`.
- All 4 units request at once (damages 1,2,3,4) with `rrPtr=0` and no ticks → acks 0,1,2,3 on consecutive cycles; four ticks → strobes carry 1,2,3,4 in order.
- Fill 8 entries, keep unit 0 requesting, no tick → no ack, `queueCount=8`; then a tick → a pop plus a push in the same cycle, `queueCount` stays 8.
- 5 entries queued, `towerDead` pulses → no strobe after the flush, `queueCount=0` within 2 cycles, state QI; further requests get no ack until `startLevel`.
- Drive `reset=0` with 3 entries queued and a tick pending → all outputs 0 immediately; after `reset=1`, ticks produce no strobes.
- Push damage 0 then tick → `attackSCEN=1`, `damageOut=0`.
